bpred_sched: RTL and testbench

BPRED_SCHED -- requirements
Module: bpred_sched

---
 rtl/bpred_pkg.sv | 22 ++
 rtl/bpred_upd_fifo.sv | 79 +++++++
 rtl/bpred_sched.sv | 130 +++++++++++++
 tb/tb_bpred_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared constants and types for the branch-predictor scheduler slice.
package bpred_pkg;

  localparam int unsigned IDX_W_DEF    = 4;
  localparam int unsigned UQ_DEPTH_DEF = 4;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Synchronous update FIFO with flush; the age-ordered entry view (index 0 = oldest)
// is only built when BPRED_FWD_EN is defined.
module bpred_upd_fifo
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned DEPTH = UQ_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_taken,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_taken
`ifdef BPRED_FWD_EN
  ,
  output logic [DEPTH-1:0][IDX_W-1:0] ent_idx,
  output logic [DEPTH-1:0]            ent_taken,
  output logic [DEPTH-1:0]            ent_vld
`endif
);

  logic [DEPTH-1:0][IDX_W-1:0] mem_idx;
  logic [DEPTH-1:0]            mem_taken;
  logic [PTR_W-1:0]            rd_ptr, wr_ptr;
  logic                        do_push, do_pop;

  always_comb begin
    full       = (count == CNT_W'(DEPTH));
    empty      = (count == '0);
    do_push    = push && !full;
    do_pop     = pop && !empty;
    head_idx   = mem_idx[rd_ptr];
    head_taken = mem_taken[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_idx[wr_ptr]   <= push_idx;
      mem_taken[wr_ptr] <= push_taken;
    end
  end

`ifdef BPRED_FWD_EN
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_idx[i]   = mem_idx[rd_ptr + PTR_W'(i)];
      ent_taken[i] = mem_taken[rd_ptr + PTR_W'(i)];
      ent_vld[i]   = (CNT_W'(i) < count);
    end
  end
`endif

endmodule

// File: rtl/bpred_sched.sv
// 2-bit-counter PHT with a single access port shared between lookups and queued
// updates, plus a sequential table clear. Optional forwarding macro: BPRED_FWD_EN.
module bpred_sched
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned UQ_DEPTH = UQ_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned CNT_W   = $clog2(UQ_DEPTH) + 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_idx;
  logic [1:0]       pht [ENTRIES];

  logic             uq_push, uq_pop, uq_flush;
  logic             uq_full, uq_empty;
  logic [CNT_W-1:0] uq_count;
  logic [IDX_W-1:0] uq_head_idx;
  logic             uq_head_taken;
  logic             lk_fire, pred_nxt;
  logic [1:0]       lk_ctr;

`ifdef BPRED_FWD_EN
  logic [UQ_DEPTH-1:0][IDX_W-1:0] uq_ent_idx;
  logic [UQ_DEPTH-1:0]            uq_ent_taken;
  logic [UQ_DEPTH-1:0]            uq_ent_vld;
`endif

  bpred_upd_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (UQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (uq_flush),
    .push       (uq_push),
    .push_idx   (upd_idx),
    .push_taken (upd_taken),
    .pop        (uq_pop),
    .full       (uq_full),
    .empty      (uq_empty),
    .count      (uq_count),
    .head_idx   (uq_head_idx),
    .head_taken (uq_head_taken)
`ifdef BPRED_FWD_EN
    ,
    .ent_idx    (uq_ent_idx),
    .ent_taken  (uq_ent_taken),
    .ent_vld    (uq_ent_vld)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (clear) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_idx == IDX_W'(ENTRIES - 1)) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // A full queue steals the port from lookups so updates can never starve.
  always_comb begin
    lk_ready  = (state == ST_RUN) && !uq_full;
    upd_ready = (state == ST_RUN) && (uq_count < CNT_W'(UQ_DEPTH));
    busy      = (state == ST_CLEAR);
    lk_fire   = lk_valid && lk_ready;
    uq_push   = upd_valid && upd_ready;
    uq_pop    = (state == ST_RUN) && !uq_empty && (uq_full || !lk_valid);
    uq_flush  = (state == ST_RUN) && clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
    else                        clr_idx <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) pht[i] <= CTR_ST;
    end else if (state == ST_CLEAR) begin
      pht[clr_idx] <= CTR_ST;
    end else if (uq_pop) begin
      pht[uq_head_idx] <= ctr_next(pht[uq_head_idx], uq_head_taken);
    end
  end

  // Forwarding scans oldest to newest so the newest matching update wins.
  always_comb begin
    lk_ctr   = pht[lk_idx];
    pred_nxt = (lk_ctr > CTR_WNT);
`ifdef BPRED_FWD_EN
    for (int unsigned i = 0; i < UQ_DEPTH; i++)
      if (uq_ent_vld[i] && (uq_ent_idx[i] == lk_idx)) pred_nxt = uq_ent_taken[i];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= lk_fire;
      if (lk_fire) pred_taken <= pred_nxt;
    end
  end

endmodule

// File: tb/tb_bpred_sched.sv
// Self-checking bench for bpred_sched: queue-based reference model plus directed scenarios.
module tb_bpred_sched;

  localparam int IW = 4;
  localparam int N  = 16;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n, clear, lk_valid, upd_valid, upd_taken;
  logic [IW-1:0] lk_idx, upd_idx;
  logic lk_ready, pred_valid, pred_taken, upd_ready, busy;

  bpred_sched #(.IDX_W(IW), .UQ_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit taken; } upd_t;
  int   m_pht [N];
  upd_t m_q [$];
  bit   m_clearing, m_pv, m_pt;
  int   m_clr;
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pht[i] = 3;
    m_q.delete();
    m_clearing = 0; m_clr = 0; m_pv = 0; m_pt = 0;
  endtask

  task automatic model_step();
    int sz;
    bit full, p;
    upd_t u;
    if (!rst_n) begin model_reset(); return; end
    if (m_clearing) begin
      m_pht[m_clr] = 3;
      m_clr++;
      if (m_clr == N) m_clearing = 0;
      m_pv = 0;
      return;
    end
    sz = m_q.size();
    full = (sz == D);
    m_pv = lk_valid && !full;
    if (m_pv) begin
      p = (m_pht[int'(lk_idx)] >= 2);
`ifdef BPRED_FWD_EN
      foreach (m_q[i]) if (m_q[i].idx == int'(lk_idx)) p = m_q[i].taken;
`endif
      m_pt = p;
    end
    if (sz > 0 && (full || !lk_valid)) begin
      u = m_q.pop_front();
      if (u.taken) m_pht[u.idx] = (m_pht[u.idx] == 3) ? 3 : m_pht[u.idx] + 1;
      else         m_pht[u.idx] = (m_pht[u.idx] == 0) ? 0 : m_pht[u.idx] - 1;
    end
    if (upd_valid && sz < D) begin
      u.idx = int'(upd_idx); u.taken = upd_taken;
      m_q.push_back(u);
    end
    if (clear) begin
      m_q.delete();
      m_clearing = 1;
      m_clr = 0;
    end
  endtask

  task automatic compare_all();
    chk("lk_ready",   lk_ready,   !m_clearing && m_q.size() < D);
    chk("upd_ready",  upd_ready,  !m_clearing && m_q.size() < D);
    chk("busy",       busy,       m_clearing);
    chk("pred_valid", pred_valid, m_pv);
    if (m_pv) chk("pred_taken", pred_taken, m_pt);
  endtask

  task automatic tick();
    @(posedge clk); model_step();
    @(negedge clk); compare_all();
  endtask

  task automatic idle();
    clear = 0; lk_valid = 0; upd_valid = 0;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic push_upd(input int idx, input bit t);
    idle();
    upd_valid = 1; upd_idx = IW'(idx); upd_taken = t;
    tick();
    upd_valid = 0;
  endtask

  task automatic lookup(input int idx);
    idle();
    lk_valid = 1; lk_idx = IW'(idx);
    tick();
    lk_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 0; idle(); lk_idx = '0; upd_idx = '0; upd_taken = 0;
    model_reset();
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pred_valid", pred_valid, 1'b0);
    chk("rst_pred_taken", pred_taken, 1'b0);
    chk("rst_upd_ready", upd_ready, 1'b1);
    chk("rst_lk_ready", lk_ready, 1'b1);
    @(negedge clk); tick();
    rst_n = 1;
    tick();

    // Fresh table predicts taken.
    lookup(3);
    chk("lk3_valid", pred_valid, 1'b1);
    chk("lk3_taken", pred_taken, 1'b1);
    tick();
    chk("lk3_one_cycle", pred_valid, 1'b0);

    // Three not-taken updates drive idx 5 to strongly not-taken; a fourth must not wrap.
    repeat (3) push_upd(5, 0);
    drain(3);
    lookup(5);
    chk("idx5_nt", pred_taken, 1'b0);
    push_upd(5, 0); drain(2);
    push_upd(5, 1); drain(2);
    lookup(5);
    chk("idx5_sat_low", pred_taken, 1'b0);
    push_upd(5, 1); drain(2);
    lookup(5);
    chk("idx5_wt", pred_taken, 1'b1);

    // Lookups hold the port until the queue fills.
    idle(); lk_valid = 1; lk_idx = 4'd1;
    for (int i = 0; i < D; i++) begin
      upd_valid = 1; upd_idx = IW'(9 + i); upd_taken = 1;
      tick();
    end
    upd_valid = 0;
    chk("full_upd_ready", upd_ready, 1'b0);
    chk("full_lk_ready", lk_ready, 1'b0);
    tick();
    chk("full_no_pred", pred_valid, 1'b0);
    chk("drain_lk_ready", lk_ready, 1'b1);
    drain(6);

    // Queued not-taken update to idx 7 is visible only with forwarding.
    idle(); lk_valid = 1; lk_idx = 4'd0;
    upd_valid = 1; upd_idx = 4'd7; upd_taken = 0;
    tick();
    upd_valid = 0; lk_idx = 4'd7;
    tick();
    chk("fwd_valid", pred_valid, 1'b1);
`ifdef BPRED_FWD_EN
    chk("fwd_taken", pred_taken, 1'b0);
`else
    chk("fwd_taken", pred_taken, 1'b1);
`endif
    drain(4);

    // Clear restores a modified entry and discards a pending update.
    push_upd(2, 0); push_upd(2, 0); drain(3);
    lookup(2);
    chk("idx2_pre_clear", pred_taken, 1'b0);
    idle(); lk_valid = 1; lk_idx = 4'd6; upd_valid = 1; upd_idx = 4'd2; upd_taken = 0;
    tick();
    idle(); clear = 1; lk_valid = 1; lk_idx = 4'd2;
    tick();
    idle();
    chk("clear_lk_pred", pred_valid, 1'b1);
    cnt = 0;
    while (busy && cnt < 100) begin
      chk("clear_upd_ready", upd_ready, 1'b0);
      cnt++;
      tick();
    end
    tests++;
    if (cnt != N) begin
      fails++;
      $display("FAIL clear_len: got %0d busy cycles expected %0d", cnt, N);
    end
    chk("post_clear_upd_ready", upd_ready, 1'b1);
    drain(2);
    lookup(2);
    chk("idx2_post_clear", pred_taken, 1'b1);

    // Reset in the middle of a clear restores every counter.
    push_upd(12, 0); push_upd(12, 0); drain(3);
    idle(); clear = 1; tick(); idle();
    repeat (8) tick();
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_upd_ready", upd_ready, 1'b1);
    chk("abort_pred_valid", pred_valid, 1'b0);
    model_reset();
    @(negedge clk); tick();
    rst_n = 1;
    for (int i = 0; i < N; i++) begin
      lookup(i);
      chk("abort_ctr", pred_taken, 1'b1);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      clear     = ($urandom_range(0, 99) == 0);
      lk_valid  = ($urandom_range(0, 9) < 7);
      lk_idx    = IW'($urandom_range(0, N - 1));
      upd_valid = ($urandom_range(0, 9) < 6);
      upd_idx   = IW'($urandom_range(0, N - 1));
      upd_taken = $urandom_range(0, 1);
      tick();
    end
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
